dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 23 ++
 rtl/dmem_arbiter_rr.sv | 34 +++
 rtl/dmem_arbiter.sv | 151 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared constants, state encoding and packed-slice helpers for dmem_arbiter.
package dmem_arb_pkg;

  localparam int NCORE_DEF = 4;
  localparam int AW_DEF    = 16;
  localparam int DW_DEF    = 16;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ISSUE = 2'd1;
  localparam state_t S_WAIT  = 2'd2;
  localparam state_t S_RESP  = 2'd3;

  // Core i occupies bits [i*w +: w] of a flattened per-core bus.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

  function automatic int slice_hi(input int idx, input int w);
    return idx * w + w - 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Combinational round-robin picker: first set req at or above rr_ptr, with wrap.
module rr_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NCORE = NCORE_DEF,
  parameter int IW    = 2
) (
  input  logic [NCORE-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic [IW-1:0]    winner,
  output logic             valid
);

  logic [NCORE-1:0] rot;

  // Rotate so rr_ptr lands at bit 0; lowest set bit of rot is the winner.
  assign rot = NCORE'({req, req} >> rr_ptr);

  always_comb begin
    int s;
    s      = 0;
    winner = '0;
    valid  = 1'b0;
    for (int k = NCORE - 1; k >= 0; k--) begin
      if (rot[k]) begin
        s = int'(rr_ptr) + k;
        if (s >= NCORE) s = s - NCORE;
        valid  = 1'b1;
        winner = IW'(s);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory among NCORE cores.
// Define DMEM_ARB_RDCOMBINE_EN to ack all same-address readers off one read.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NCORE   = NCORE_DEF,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NCORE-1:0]    req,
  input  logic [NCORE-1:0]    we,
  input  logic [NCORE*AW-1:0] addr,
  input  logic [NCORE*DW-1:0] wdata,
  output logic [NCORE-1:0]    ack,
  output logic [DW-1:0]       rdata,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_din,
  output logic                mem_read,
  output logic                mem_write,
  input  logic [DW-1:0]       mem_dout,
  output logic                busy
);

  localparam int IW = (NCORE > 1) ? $clog2(NCORE) : 1;
  localparam int CW = $clog2(MEM_LAT + 1);

  state_t            state_q, state_d;
  logic [IW-1:0]     win_q, win_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              we_q, we_d;
  logic [AW-1:0]     maddr_q, maddr_d;
  logic [DW-1:0]     mdin_q, mdin_d;
  logic              mrd_q, mrd_d;
  logic              mwr_q, mwr_d;
  logic [NCORE-1:0]  ack_q, ack_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [IW-1:0]     arb_win;
  logic              arb_vld;

  rr_arbiter #(.NCORE(NCORE), .IW(IW)) u_rr (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .winner (arb_win),
    .valid  (arb_vld)
  );

`ifdef DMEM_ARB_RDCOMBINE_EN
  // Other readers parked on the address being read can share this result.
  logic [NCORE-1:0] comb_hit;
  for (genvar g = 0; g < NCORE; g++) begin : g_hit
    assign comb_hit[g] = req[g] && !we[g] && (addr[g*AW +: AW] == maddr_q);
  end
`endif

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    rr_ptr_d = rr_ptr_q;
    we_d     = we_q;
    maddr_d  = maddr_q;
    mdin_d   = mdin_q;
    mrd_d    = 1'b0;
    mwr_d    = 1'b0;
    ack_d    = '0;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (arb_vld) begin
          state_d = S_ISSUE;
          win_d   = arb_win;
          we_d    = we[arb_win];
          maddr_d = addr[slice_lo(int'(arb_win), AW) +: AW];
          mdin_d  = wdata[slice_lo(int'(arb_win), DW) +: DW];
          mrd_d   = !we[arb_win];
          mwr_d   = we[arb_win];
        end
      end
      S_ISSUE: begin
        if (we_q || MEM_LAT == 1) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CW'(MEM_LAT - 2);
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_RESP: begin
        state_d  = S_IDLE;
        rr_ptr_d = (win_q == IW'(NCORE - 1)) ? '0 : win_q + IW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // ack and rdata are registered on the edge that enters RESP.
    if (state_d == S_RESP && state_q != S_RESP) begin
      ack_d[win_q] = 1'b1;
      if (!we_q) begin
        rdata_d = mem_dout;
`ifdef DMEM_ARB_RDCOMBINE_EN
        ack_d = ack_d | comb_hit;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      win_q    <= '0;
      rr_ptr_q <= '0;
      we_q     <= 1'b0;
      maddr_q  <= '0;
      mdin_q   <= '0;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
      ack_q    <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      maddr_q  <= maddr_d;
      mdin_q   <= mdin_d;
      mrd_q    <= mrd_d;
      mwr_q    <= mwr_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign mem_addr  = maddr_q;
  assign mem_din   = mdin_q;
  assign mem_read  = mrd_q;
  assign mem_write = mwr_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table plus multi-cycle sequences.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int NC = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst1, rst3;
  logic [NC-1:0]   req1, req3, we;
  logic [NC*AW-1:0] addr;
  logic [NC*DW-1:0] wdata;
  logic [NC-1:0]   ack1, ack3;
  logic [DW-1:0]   rdata1, rdata3, mdin1, mdin3, mdout1, mdout3;
  logic [AW-1:0]   maddr1, maddr3;
  logic            mrd1, mwr1, mrd3, mwr3, busy1, busy3;

  function automatic logic [15:0] mem_model(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  assign mdout1 = mem_model(maddr1);
  assign mdout3 = mem_model(maddr3);

  dmem_arbiter #(.NCORE(NC), .AW(AW), .DW(DW), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(rst1), .req(req1), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack1), .rdata(rdata1), .mem_addr(maddr1), .mem_din(mdin1),
    .mem_read(mrd1), .mem_write(mwr1), .mem_dout(mdout1), .busy(busy1)
  );

  dmem_arbiter #(.NCORE(NC), .AW(AW), .DW(DW), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(rst3), .req(req3), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack3), .rdata(rdata3), .mem_addr(maddr3), .mem_din(mdin3),
    .mem_read(mrd3), .mem_write(mwr3), .mem_dout(mdout3), .busy(busy3)
  );

  typedef struct {
    bit          d3;
    int          core;
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    logic [3:0]  exp_ack;
    logic [15:0] exp_rdata;
    int          exp_cyc;
  } vec_t;

  typedef struct {
    logic [3:0]  ack;
    logic        rd;
    logic [15:0] rdata;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;
  int   n_vec = 0;
  int   n_err = 0;
  int   ack_cyc[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboards: every ack pops the oldest expectation for that DUT.
  always @(negedge clk) begin
    chk("rd_wr_excl1", {63'b0, mrd1 & mwr1}, 64'd0);
    if (ack1 != 4'b0) begin
      if (q1.size() == 0) chk("unexpected_ack1", {60'b0, ack1}, 64'd0);
      else begin
        e1 = q1.pop_front();
        chk("sb_ack1", {60'b0, ack1}, {60'b0, e1.ack});
        if (e1.rd) chk("sb_rdata1", {48'b0, rdata1}, {48'b0, e1.rdata});
      end
    end
  end

  always @(negedge clk) begin
    chk("rd_wr_excl3", {63'b0, mrd3 & mwr3}, 64'd0);
    if (ack3 != 4'b0) begin
      if (q3.size() == 0) chk("unexpected_ack3", {60'b0, ack3}, 64'd0);
      else begin
        e3 = q3.pop_front();
        chk("sb_ack3", {60'b0, ack3}, {60'b0, e3.ack});
        if (e3.rd) chk("sb_rdata3", {48'b0, rdata3}, {48'b0, e3.rdata});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // One isolated request; inputs are scrambled once latched to prove they are ignored.
  task automatic apply(input vec_t v);
    int lat, nrd, nwr;
    logic [15:0] ia, id, ma_s, md_s, rd_s;
    logic [3:0]  a_s;
    logic        b_s, r_s, w_s;
    addr[v.core*16 +: 16]  = v.a;
    wdata[v.core*16 +: 16] = v.d;
    we = (we & ~(4'b0001 << v.core)) | (4'(v.w) << v.core);
    if (v.d3) begin
      req3 = 4'b0001 << v.core;
      q3.push_back('{v.exp_ack, !v.w, v.exp_rdata});
    end else begin
      req1 = 4'b0001 << v.core;
      q1.push_back('{v.exp_ack, !v.w, v.exp_rdata});
    end
    lat = 0; nrd = 0; nwr = 0; ia = '0; id = '0; a_s = '0; rd_s = '0;
    while (a_s == 4'b0 && lat < 20) begin
      @(negedge clk);
      lat++;
      a_s  = v.d3 ? ack3   : ack1;
      b_s  = v.d3 ? busy3  : busy1;
      r_s  = v.d3 ? mrd3   : mrd1;
      w_s  = v.d3 ? mwr3   : mwr1;
      ma_s = v.d3 ? maddr3 : maddr1;
      md_s = v.d3 ? mdin3  : mdin1;
      rd_s = v.d3 ? rdata3 : rdata1;
      if (r_s) begin nrd++; ia = ma_s; end
      if (w_s) begin nwr++; ia = ma_s; id = md_s; end
      if (b_s) chk("mem_addr_hold", {48'b0, ma_s}, {48'b0, v.a});
      if (lat == 1) begin
        addr[v.core*16 +: 16]  = ~v.a;
        wdata[v.core*16 +: 16] = ~v.d;
        we = we ^ (4'b0001 << v.core);
      end
    end
    if (v.d3) req3 = '0; else req1 = '0;
    chk("ack_cycle", 64'(lat + 1), 64'(v.exp_cyc));
    chk("ack_core", {60'b0, a_s}, {60'b0, v.exp_ack});
    chk("rdata_at_ack", {48'b0, rd_s}, {48'b0, v.exp_rdata});
    chk("mem_read_cycles", 64'(nrd), v.w ? 64'd0 : 64'd1);
    chk("mem_write_cycles", 64'(nwr), v.w ? 64'd1 : 64'd0);
    chk("issued_addr", {48'b0, ia}, {48'b0, v.a});
    if (v.w) chk("issued_din", {48'b0, id}, {48'b0, v.d});
    @(negedge clk);
  endtask

  // Collect up to n acks on dut1, optionally dropping req of each acked core.
  task automatic run_acks1(input int n, input bit drop, output int got);
    int cyc;
    got = 0; cyc = 0;
    while (got < n && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (ack1 != 4'b0) begin
        ack_cyc[got] = cyc;
        got++;
        if (drop) req1 = req1 & ~ack1;
      end
    end
  endtask

  initial begin
    vec_t tbl[8];
    int   got;
    logic [3:0] acc;
    logic       bacc;
    tbl[0] = '{1'b0, 2, 1'b0, 16'h0010, 16'h0000, 4'b0100, 16'hBEEF, 3};
    tbl[1] = '{1'b0, 1, 1'b1, 16'h0020, 16'h1234, 4'b0010, 16'hBEEF, 3};
    tbl[2] = '{1'b0, 0, 1'b0, 16'h1234, 16'h0000, 4'b0001, 16'h486E, 3};
    tbl[3] = '{1'b0, 3, 1'b1, 16'hFFFF, 16'hA5A5, 4'b1000, 16'h486E, 3};
    tbl[4] = '{1'b0, 3, 1'b0, 16'hFFFF, 16'h0000, 4'b1000, 16'hA5A5, 3};
    tbl[5] = '{1'b0, 1, 1'b0, 16'h0000, 16'h0000, 4'b0010, 16'h5A5A, 3};
    tbl[6] = '{1'b1, 0, 1'b0, 16'h0100, 16'h0000, 4'b0001, 16'h5B5A, 5};
    tbl[7] = '{1'b1, 2, 1'b1, 16'h0300, 16'h0F0F, 4'b0100, 16'h5B5A, 3};

    req1 = '0; req3 = '0; we = '0; addr = '0; wdata = '0;
    rst1 = 1'b0; rst3 = 1'b0;
    #1 rst1 = 1'b1; rst3 = 1'b1;
    #1;
    chk("reset_outs1", {9'b0, ack1, rdata1, maddr1, mdin1, mrd1, mwr1, busy1}, 64'd0);
    chk("reset_outs3", {9'b0, ack3, rdata3, maddr3, mdin3, mrd3, mwr3, busy3}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst1 = 1'b0; rst3 = 1'b0;

    for (int i = 0; i < 8; i++) apply(tbl[i]);

    // Reset in WAIT: outputs clear without a clock edge, no ack, then a clean regrant.
    addr[32 +: 16] = 16'h0300; we = '0; req3 = 4'b0100;
    @(negedge clk); @(negedge clk);
    chk("wait_busy", {63'b0, busy3}, 64'd1);
    #1 rst3 = 1'b1;
    #1;
    chk("rst_mid_outs", {9'b0, ack3, rdata3, maddr3, mdin3, mrd3, mwr3, busy3}, 64'd0);
    req3 = '0;
    @(negedge clk);
    rst3 = 1'b0;
    acc = '0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); acc = acc | ack3; end
    chk("abort_no_ack", {60'b0, acc}, 64'd0);
    apply('{1'b1, 2, 1'b0, 16'h0300, 16'h0000, 4'b0100, 16'h595A, 5});

    // All four cores requesting continuously from rr_ptr 0.
    @(negedge clk); rst1 = 1'b1; @(negedge clk); rst1 = 1'b0;
    addr = {16'h0D00, 16'h0C00, 16'h0B00, 16'h0A00}; we = '0;
    for (int k = 0; k < 5; k++)
      q1.push_back('{4'b0001 << (k % 4), 1'b1, mem_model(16'h0A00 + 16'(k % 4) * 16'h0100)});
    req1 = 4'b1111;
    run_acks1(5, 1'b0, got);
    req1 = '0;
    chk("rr_ack_count", 64'(got), 64'd5);
    chk("rr_first_ack", 64'(ack_cyc[0]), 64'd2);
    for (int k = 1; k < 5; k++) chk("rr_gap", 64'(ack_cyc[k] - ack_cyc[k-1]), 64'd3);
    @(negedge clk);

    // Core1 raises and withdraws req while core3 is being served.
    q1.push_back('{4'b1000, 1'b1, mem_model(16'h0D00)});
    req1 = 4'b1000;
    @(negedge clk);
    req1 = 4'b1010;
    @(negedge clk);
    chk("wd_ack_core3", {60'b0, ack1}, 64'h8);
    req1 = '0;
    acc = '0; bacc = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      acc = acc | ack1; bacc = bacc | busy1;
    end
    chk("withdrawn_no_ack", {60'b0, acc}, 64'd0);
    chk("withdrawn_idle", {63'b0, bacc}, 64'd0);

    // Cores 0 and 3 read the same word; core1 reads elsewhere.
    @(negedge clk); rst1 = 1'b1; @(negedge clk); rst1 = 1'b0;
    addr = {16'h0040, 16'h0999, 16'h0050, 16'h0040}; we = '0;
`ifdef DMEM_ARB_RDCOMBINE_EN
    q1.push_back('{4'b1001, 1'b1, mem_model(16'h0040)});
    q1.push_back('{4'b0010, 1'b1, mem_model(16'h0050)});
    req1 = 4'b1011;
    run_acks1(2, 1'b1, got);
    chk("combine_acks", 64'(got), 64'd2);
`else
    q1.push_back('{4'b0001, 1'b1, mem_model(16'h0040)});
    q1.push_back('{4'b0010, 1'b1, mem_model(16'h0050)});
    q1.push_back('{4'b1000, 1'b1, mem_model(16'h0040)});
    req1 = 4'b1011;
    run_acks1(3, 1'b1, got);
    chk("single_acks", 64'(got), 64'd3);
`endif
    req1 = '0;
    repeat (4) @(negedge clk);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    chk("q3_drained", 64'(q3.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
